// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge path:
// sequencer states, OCW2 field positions and the spurious IR index.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEND = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } pic_state_t;

    localparam int unsigned OCW2_LEVEL_LSB = 0;
    localparam int unsigned OCW2_LEVEL_MSB = 2;
    localparam int unsigned OCW2_EOI_BIT   = 5;
    localparam int unsigned OCW2_SL_BIT    = 6;
    localparam int unsigned OCW2_R_BIT     = 7;

    localparam logic [2:0] SPURIOUS_IR = 3'd7;

    // Decoded OCW2 fields relevant to ISR clearing
    typedef struct packed {
        logic       eoi;
        logic       specific;
        logic [2:0] level;
    } ocw2_cmd_t;

    function automatic ocw2_cmd_t ocw2_decode(input logic [7:0] value);
        ocw2_cmd_t cmd;
        cmd.eoi      = value[OCW2_EOI_BIT];
        cmd.specific = value[OCW2_SL_BIT];
        cmd.level    = value[OCW2_LEVEL_MSB:OCW2_LEVEL_LSB];
        return cmd;
    endfunction

endpackage

// File: rtl/pic_isr_highest.sv
// Rotated first-set-bit finder: scans isr_reg starting at zero_level and
// wrapping modulo 8, returning the first in-service index found.
module pic_isr_highest
    import pic_pkg::*;
(
    input  logic [7:0] isr_reg,
    input  logic [2:0] zero_level,
    output logic [2:0] index,
    output logic       found
);

    logic [2:0] pos;

    // Priority scan from the current highest-priority level downwards
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            pos = zero_level + 3'(i);
            if (!found && isr_reg[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259A interrupt-acknowledge and end-of-interrupt sequencer.
// Raises INT, runs the two-pulse 8086 INTA cycle, presents the vector and
// turns OCW2 EOI commands into ISR-clear strobes.
// Optional feature macro: PIC_AEOI_EN (automatic EOI at the end of ACK2).
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned VEC_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             int_request,
    input  logic [2:0]       resolved_index,
    input  logic             inta_n,
    input  logic [4:0]       icw2_base,
    input  logic [7:0]       isr_reg,
    input  logic [2:0]       zero_level,
    input  logic [7:0]       ocw2,
    input  logic             ocw2_wr,
    input  logic             aeoi,
    output logic             int_out,
    output logic             freeze,
    output logic             isr_set,
    output logic [2:0]       ack_index,
    output logic             isr_clr,
    output logic [2:0]       clr_index,
    output logic [VEC_W-1:0] data_out,
    output logic             data_oe
);

    pic_state_t state;
    logic       spurious;
    logic       inta_q;
    logic       inta_prev;
    logic       inta_fall;
    logic       inta_rise;
    logic       aeoi_active;
    logic       aeoi_fire;

    ocw2_cmd_t  cmd;
    logic [2:0] hi_index;
    logic       hi_found;
    logic       eoi_accept;
    logic [2:0] eoi_idx_new;

    logic [2:0] q_slot0;
    logic [2:0] q_slot1;
    logic [1:0] q_cnt;
    logic       q_deq;
    logic [2:0] q_slot0_nxt;
    logic [2:0] q_slot1_nxt;
    logic [1:0] q_cnt_nxt;

`ifdef PIC_AEOI_EN
    assign aeoi_active = aeoi;
`else
    // Automatic EOI is not built in; the input is tied off here
    assign aeoi_active = aeoi & 1'b0;
`endif

    assign inta_fall = inta_prev & ~inta_q;
    assign inta_rise = ~inta_prev & inta_q;
    assign aeoi_fire = (state == ACK2) && inta_rise && aeoi_active && !spurious;

    assign cmd = ocw2_decode(ocw2);

    pic_isr_highest u_isr_highest (
        .isr_reg    (isr_reg),
        .zero_level (zero_level),
        .index      (hi_index),
        .found      (hi_found)
    );

    // Register INTA once and keep the previous sample for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inta_q    <= 1'b1;
            inta_prev <= 1'b1;
        end else begin
            inta_q    <= inta_n;
            inta_prev <= inta_q;
        end
    end

    // INTA sequencing FSM with registered bus-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            int_out   <= 1'b0;
            freeze    <= 1'b0;
            isr_set   <= 1'b0;
            ack_index <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            isr_set <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (int_request) state <= PEND;
                end
                PEND: begin
                    if (inta_fall) begin
                        state   <= ACK1;
                        int_out <= 1'b0;
                        freeze  <= 1'b1;
                        if (int_request) begin
                            ack_index <= resolved_index;
                            isr_set   <= 1'b1;
                            spurious  <= 1'b0;
                        end else begin
                            ack_index <= SPURIOUS_IR;
                            spurious  <= 1'b1;
                        end
                    end else begin
                        int_out <= 1'b1;
                    end
                end
                ACK1: begin
                    if (inta_rise) state <= GAP;
                end
                GAP: begin
                    if (inta_fall) begin
                        state    <= ACK2;
                        data_oe  <= 1'b1;
                        data_out <= VEC_W'({icw2_base, ack_index});
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state    <= IDLE;
                        data_oe  <= 1'b0;
                        data_out <= '0;
                        freeze   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Resolve an OCW2 write into an ISR index to clear, if any
    always_comb begin
        eoi_accept  = 1'b0;
        eoi_idx_new = '0;
        if (ocw2_wr && cmd.eoi) begin
            if (cmd.specific) begin
                eoi_accept  = 1'b1;
                eoi_idx_new = cmd.level;
            end else if (hi_found) begin
                eoi_accept  = 1'b1;
                eoi_idx_new = hi_index;
            end
        end
    end

    // Two-entry EOI queue: an AEOI strobe takes the output slot first, so an
    // EOI landing in the same cycle waits one cycle instead of being lost
    always_comb begin
        q_deq       = (q_cnt != 2'd0) && !aeoi_fire;
        q_cnt_nxt   = q_cnt - 2'(q_deq);
        q_slot0_nxt = q_deq ? q_slot1 : q_slot0;
        q_slot1_nxt = q_slot1;
        if (eoi_accept) begin
            if (q_cnt_nxt == 2'd0) q_slot0_nxt = eoi_idx_new;
            else                   q_slot1_nxt = eoi_idx_new;
            q_cnt_nxt = q_cnt_nxt + 2'd1;
        end
    end

    // ISR-clear strobe generation from AEOI or queued EOI commands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_slot0   <= '0;
            q_slot1   <= '0;
            q_cnt     <= '0;
            isr_clr   <= 1'b0;
            clr_index <= '0;
        end else begin
            q_slot0 <= q_slot0_nxt;
            q_slot1 <= q_slot1_nxt;
            q_cnt   <= q_cnt_nxt;
            isr_clr <= 1'b0;
            if (aeoi_fire) begin
                isr_clr   <= 1'b1;
                clr_index <= ack_index;
            end else if (q_cnt != 2'd0) begin
                isr_clr   <= 1'b1;
                clr_index <= q_slot0;
            end
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: scoreboard queues hold the
// expected isr_set indices, isr_clr indices and vectors; a negedge monitor
// pops and compares them as the DUT produces each event.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       int_request = 1'b0;
    logic [2:0] resolved_index = '0;
    logic       inta_n = 1'b1;
    logic [4:0] icw2_base = '0;
    logic [7:0] isr_reg = '0;
    logic [2:0] zero_level = '0;
    logic [7:0] ocw2 = '0;
    logic       ocw2_wr = 1'b0;
    logic       aeoi = 1'b0;
    logic       int_out;
    logic       freeze;
    logic       isr_set;
    logic [2:0] ack_index;
    logic       isr_clr;
    logic [2:0] clr_index;
    logic [7:0] data_out;
    logic       data_oe;

    int checks_total  = 0;
    int checks_passed = 0;
    int set_seen = 0;
    int clr_seen = 0;

    logic [2:0] exp_set_q[$];
    logic [2:0] exp_clr_q[$];
    logic [7:0] exp_vec_q[$];
    logic [2:0] e_idx;
    logic [7:0] e_vec;
    logic       oe_prev = 1'b0;

    pic_inta_sequencer #(.VEC_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .int_request    (int_request),
        .resolved_index (resolved_index),
        .inta_n         (inta_n),
        .icw2_base      (icw2_base),
        .isr_reg        (isr_reg),
        .zero_level     (zero_level),
        .ocw2           (ocw2),
        .ocw2_wr        (ocw2_wr),
        .aeoi           (aeoi),
        .int_out        (int_out),
        .freeze         (freeze),
        .isr_set        (isr_set),
        .ack_index      (ack_index),
        .isr_clr        (isr_clr),
        .clr_index      (clr_index),
        .data_out       (data_out),
        .data_oe        (data_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    // Scoreboard monitor: every DUT strobe/vector must match the queue head
    always @(negedge clk) begin
        if (reset_n) begin
            if (isr_set) begin
                set_seen++;
                checks_total++;
                if (exp_set_q.size() == 0) begin
                    $display("FAIL isr_set_unexpected: got pulse ack_index=%0d, expected none", ack_index);
                end else begin
                    e_idx = exp_set_q.pop_front();
                    if (ack_index !== e_idx)
                        $display("FAIL isr_set_index: got %0d expected %0d", ack_index, e_idx);
                    else checks_passed++;
                end
            end
            if (isr_clr) begin
                clr_seen++;
                checks_total++;
                if (exp_clr_q.size() == 0) begin
                    $display("FAIL isr_clr_unexpected: got pulse clr_index=%0d, expected none", clr_index);
                end else begin
                    e_idx = exp_clr_q.pop_front();
                    if (clr_index !== e_idx)
                        $display("FAIL isr_clr_index: got %0d expected %0d", clr_index, e_idx);
                    else checks_passed++;
                end
            end
            if (data_oe && !oe_prev) begin
                checks_total++;
                if (exp_vec_q.size() == 0) begin
                    $display("FAIL vector_unexpected: got data_out=%02h, expected no drive", data_out);
                end else begin
                    e_vec = exp_vec_q.pop_front();
                    if (data_out !== e_vec)
                        $display("FAIL vector_value: got %02h expected %02h", data_out, e_vec);
                    else checks_passed++;
                end
            end
        end
        oe_prev = data_oe;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks_total++;
        if ({int_out, freeze, isr_set, isr_clr, data_oe} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {int_out, freeze, isr_set, isr_clr, data_oe});
        else checks_passed++;
        checks_total++;
        if ({ack_index, clr_index, data_out} !== 14'h0)
            $display("FAIL reset_values: got %h expected 0", {ack_index, clr_index, data_out});
        else checks_passed++;
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ignored_inta();
        int set_before;
        set_before = set_seen;
        inta_n = 1'b0;
        tick(3);
        inta_n = 1'b1;
        tick(3);
        checks_total++;
        if ({freeze, data_oe, int_out} !== 3'b000 || set_seen != set_before)
            $display("FAIL idle_inta: got freeze/oe/int=%b sets=%0d expected 000 sets=%0d",
                     {freeze, data_oe, int_out}, set_seen, set_before);
        else checks_passed++;
    endtask

    task automatic test_inta_normal();
        icw2_base = 5'h08;
        resolved_index = 3'd3;
        int_request = 1'b1;
        tick();
        checks_total++;
        if (int_out !== 1'b0) $display("FAIL int_out_early: got %b expected 0", int_out);
        else checks_passed++;
        tick();
        checks_total++;
        if (int_out !== 1'b1) $display("FAIL int_out_latency: got %b expected 1", int_out);
        else checks_passed++;
        exp_set_q.push_back(3'd3);
        exp_vec_q.push_back(8'h43);
        inta_n = 1'b0;
        tick(2);
        checks_total++;
        if ({isr_set, freeze, int_out, ack_index} !== {3'b110, 3'd3})
            $display("FAIL ack1_entry: got set/frz/int/idx=%b_%0d expected 110_3",
                     {isr_set, freeze, int_out}, ack_index);
        else checks_passed++;
        int_request = 1'b0;
        tick();
        checks_total++;
        if (isr_set !== 1'b0) $display("FAIL isr_set_width: got %b expected 0", isr_set);
        else checks_passed++;
        inta_n = 1'b1;
        tick(3);
        checks_total++;
        if ({freeze, data_oe} !== 2'b10) $display("FAIL gap_state: got frz/oe=%b expected 10", {freeze, data_oe});
        else checks_passed++;
        inta_n = 1'b0;
        tick();
        checks_total++;
        if (data_oe !== 1'b0) $display("FAIL data_oe_early: got %b expected 0", data_oe);
        else checks_passed++;
        tick();
        checks_total++;
        if ({data_oe, freeze, data_out} !== {2'b11, 8'h43})
            $display("FAIL ack2_vector: got oe/frz/data=%b_%02h expected 11_43", {data_oe, freeze}, data_out);
        else checks_passed++;
        tick(2);
        inta_n = 1'b1;
        tick();
        checks_total++;
        if (data_oe !== 1'b1) $display("FAIL data_oe_hold: got %b expected 1", data_oe);
        else checks_passed++;
        tick();
        checks_total++;
        if ({data_oe, freeze} !== 2'b00) $display("FAIL ack2_exit: got oe/frz=%b expected 00", {data_oe, freeze});
        else checks_passed++;
        tick(2);
    endtask

    task automatic test_spurious();
        int set_before;
        set_before = set_seen;
        resolved_index = 3'd3;
        int_request = 1'b1;
        tick(2);
        int_request = 1'b0;
        tick(2);
        checks_total++;
        if (int_out !== 1'b1) $display("FAIL spurious_pend_hold: got int_out=%b expected 1", int_out);
        else checks_passed++;
        exp_vec_q.push_back(8'h47);
        inta_n = 1'b0;
        tick(2);
        checks_total++;
        if ({isr_set, freeze, ack_index} !== {2'b01, 3'd7})
            $display("FAIL spurious_ack: got set/frz/idx=%b_%0d expected 01_7", {isr_set, freeze}, ack_index);
        else checks_passed++;
        tick();
        inta_n = 1'b1;
        tick(3);
        inta_n = 1'b0;
        tick(2);
        checks_total++;
        if ({data_oe, data_out} !== {1'b1, 8'h47})
            $display("FAIL spurious_vector: got oe/data=%b_%02h expected 1_47", data_oe, data_out);
        else checks_passed++;
        inta_n = 1'b1;
        tick(3);
        checks_total++;
        if (set_seen != set_before) $display("FAIL spurious_no_set: got %0d pulses expected 0", set_seen - set_before);
        else checks_passed++;
    endtask

    task automatic test_eoi();
        logic [7:0] isr_tab [5] = '{8'b0010_0100, 8'h00,  8'b0000_0010, 8'b1000_0001, 8'b0000_0000};
        logic [2:0] zl_tab  [5] = '{3'd4,         3'd0,   3'd6,         3'd1,         3'd0};
        logic [7:0] ocw_tab [5] = '{8'h20,        8'h62,  8'hA0,        8'h20,        8'h20};
        logic [2:0] exp_tab [5] = '{3'd5,         3'd2,   3'd1,         3'd7,         3'd0};
        for (int i = 0; i < 5; i++) begin
            isr_reg = isr_tab[i];
            zero_level = zl_tab[i];
            ocw2 = ocw_tab[i];
            ocw2_wr = 1'b1;
            if (i < 4) exp_clr_q.push_back(exp_tab[i]);
            tick();
            ocw2_wr = 1'b0;
            checks_total++;
            if (isr_clr !== 1'b0) $display("FAIL eoi_early_%0d: got %b expected 0", i, isr_clr);
            else checks_passed++;
            tick();
            checks_total++;
            if (i < 4) begin
                if ({isr_clr, clr_index} !== {1'b1, exp_tab[i]})
                    $display("FAIL eoi_strobe_%0d: got clr/idx=%b_%0d expected 1_%0d", i, isr_clr, clr_index, exp_tab[i]);
                else checks_passed++;
            end else begin
                if (isr_clr !== 1'b0) $display("FAIL eoi_empty: got %b expected 0", isr_clr);
                else checks_passed++;
            end
            tick(2);
        end
    endtask

    task automatic test_non_eoi_write();
        int clr_before;
        clr_before = clr_seen;
        isr_reg = 8'hFF;
        ocw2 = 8'h42;
        ocw2_wr = 1'b1;
        tick();
        ocw2_wr = 1'b0;
        tick(3);
        checks_total++;
        if (clr_seen != clr_before) $display("FAIL non_eoi_write: got %0d strobes expected 0", clr_seen - clr_before);
        else checks_passed++;
    endtask

    task automatic test_aeoi_collision();
        aeoi = 1'b1;
        isr_reg = 8'b0000_1000;
        zero_level = 3'd0;
        resolved_index = 3'd6;
        int_request = 1'b1;
        tick(2);
        exp_set_q.push_back(3'd6);
        exp_vec_q.push_back(8'h46);
        inta_n = 1'b0;
        tick(2);
        int_request = 1'b0;
        tick();
        inta_n = 1'b1;
        tick(3);
        inta_n = 1'b0;
        tick(3);
`ifdef PIC_AEOI_EN
        exp_clr_q.push_back(3'd6);
`endif
        exp_clr_q.push_back(3'd3);
        inta_n = 1'b1;
        ocw2 = 8'h20;
        ocw2_wr = 1'b1;
        tick();
        ocw2_wr = 1'b0;
        checks_total++;
        if (isr_clr !== 1'b0) $display("FAIL aeoi_early: got %b expected 0", isr_clr);
        else checks_passed++;
        tick();
        checks_total++;
`ifdef PIC_AEOI_EN
        if ({isr_clr, clr_index} !== {1'b1, 3'd6})
            $display("FAIL aeoi_strobe: got clr/idx=%b_%0d expected 1_6", isr_clr, clr_index);
        else checks_passed++;
        tick();
        checks_total++;
`endif
        if ({isr_clr, clr_index} !== {1'b1, 3'd3})
            $display("FAIL eoi_after_aeoi: got clr/idx=%b_%0d expected 1_3", isr_clr, clr_index);
        else checks_passed++;
        tick();
        checks_total++;
        if (isr_clr !== 1'b0) $display("FAIL eoi_tail: got %b expected 0", isr_clr);
        else checks_passed++;
        aeoi = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_in_gap();
        resolved_index = 3'd1;
        int_request = 1'b1;
        tick(2);
        exp_set_q.push_back(3'd1);
        inta_n = 1'b0;
        tick(2);
        int_request = 1'b0;
        tick();
        inta_n = 1'b1;
        tick(2);
        checks_total++;
        if (freeze !== 1'b1) $display("FAIL gap_freeze: got %b expected 1", freeze);
        else checks_passed++;
        #2 reset_n = 1'b0;
        #1;
        checks_total++;
        if ({data_oe, freeze, int_out, isr_set, isr_clr} !== 5'b0)
            $display("FAIL async_reset: got oe/frz/int/set/clr=%b expected 00000",
                     {data_oe, freeze, int_out, isr_set, isr_clr});
        else checks_passed++;
        tick();
        reset_n = 1'b1;
        tick(2);
        int_request = 1'b1;
        tick();
        checks_total++;
        if (int_out !== 1'b0) $display("FAIL post_reset_idle: got %b expected 0", int_out);
        else checks_passed++;
        tick();
        checks_total++;
        if (int_out !== 1'b1) $display("FAIL post_reset_pend: got %b expected 1", int_out);
        else checks_passed++;
        int_request = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_ignored_inta();
        test_inta_normal();
        test_spurious();
        test_eoi();
        test_non_eoi_write();
        test_aeoi_collision();
        test_reset_in_gap();
        checks_total++;
        if (exp_set_q.size() + exp_clr_q.size() + exp_vec_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending expected 0/0/0",
                     exp_set_q.size(), exp_clr_q.size(), exp_vec_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Synchronous interrupt-acknowledge and end-of-interrupt sequencer for the 8259A PIC. It sits between the priority resolver and the CPU bus interface:
- raises INT to the CPU when the resolver requests;
- runs the two-pulse 8086 INTA cycle, freezing the resolver and moving the winning request from IRR to ISR;
- drives the interrupt vector onto the data bus;
- decodes OCW2 EOI commands into ISR-clear strobes.

## Interface
- VEC_W, 8: data bus / vector width.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- int_request  in  1  resolver request level (high = unmasked winner outranks ISR).
- resolved_index  in  3  resolver winning IR index, valid while int_request high.
- inta_n  in  1  CPU acknowledge, active low, already synchronous to clk.
- icw2_base  in  5  ICW2 T7..T3, vector upper bits.
- isr_reg  in  8  current in-service register.
- zero_level  in  3  IR index currently holding highest priority.
- ocw2  in  8  OCW2 value, sampled when ocw2_wr high.
- ocw2_wr  in  1  one-cycle write strobe for OCW2.
- aeoi  in  1  ICW4 AEOI bit (ignored unless PIC_AEOI_EN).
- int_out  out  1  INT pin to CPU.
- freeze  out  1  holds resolver IRR snapshot.
- isr_set  out  1  one-cycle strobe: set ISR[ack_index], clear IRR[ack_index].
- ack_index  out  3  index latched at first INTA.
- isr_clr  out  1  one-cycle strobe: clear ISR[clr_index].
- clr_index  out  3  index to clear; also feeds resolver's reset-ISR index.
- data_out  out  VEC_W  vector {icw2_base, ack_index}.
- data_oe  out  1  data bus drive enable.

## Operation
- FSM states: IDLE, PEND, ACK1, GAP, ACK2.
- inta_n is registered once; fall and rise are detected as (prev, cur) = (1,0) and (0,1).
- IDLE: int_request=1 → PEND.
- PEND:
  - int_out=1.
  - INTA fall → ACK1.
    - Latch ack_index = resolved_index, pulse isr_set, assert freeze.
    - If int_request has dropped by the fall: spurious. ack_index=7, no isr_set.
  - int_request drops with no INTA fall → stay in PEND (the spurious case is resolved at INTA).
- ACK1: int_out=0. INTA rise → GAP.
- GAP: INTA fall → ACK2. data_oe=1, data_out valid.
- ACK2: INTA rise → drop data_oe and freeze, then:
  - With AEOI active and the cycle not spurious: pulse isr_clr with clr_index=ack_index.
  - Return to IDLE.
- EOI decode: on ocw2_wr with ocw2[5]=1 (any state):
  - Non-specific (ocw2[6]=0): clr_index = first set bit of isr_reg scanning zero_level, zero_level+1, … mod 8. If isr_reg==0, no strobe.
  - Specific (ocw2[6]=1): clr_index = ocw2[2:0].
  - isr_clr is pulsed the next cycle.
- ocw2[5]=0 writes produce no strobe.
- If an EOI strobe and an AEOI strobe fall in the same cycle, AEOI wins and the EOI is deferred one cycle. Never drop either.

## Timing
- Reset values: state IDLE, int_out=0, freeze=0, isr_set=0, isr_clr=0, ack_index=0, clr_index=0, data_out=0, data_oe=0.
- int_request rise → int_out high 2 cycles later (IDLE→PEND, registered output).
- INTA fall on inta_n at cycle N → isr_set/freeze high at N+2. isr_set is exactly one cycle.
- Second INTA fall at M → data_oe high at M+2. Held until 2 cycles after the rise.
- ocw2_wr at cycle K → isr_clr at K+2. clr_index is valid in the same cycle as isr_clr.
- INTA pulses outside PEND/ACK1/GAP are ignored.
- reset_n assertion mid-cycle: all outputs return to reset values immediately (async), without a clr/set pulse.

## Configuration
- PIC_AEOI_EN defined: the aeoi input is honoured and the ISR is cleared automatically at the end of ACK2.
- Undefined: the aeoi input is unused, and the ISR is cleared only by OCW2 EOI.

## Structure
- Shared package pic_pkg holds:
  - the state enum;
  - OCW2 field constants (EOI bit 5, SL bit 6, R bit 7, level bits 2:0);
  - SPURIOUS_IR = 3'd7.
- Sub-module pic_isr_highest: combinational rotated first-set-bit finder (isr_reg, zero_level → index, found). The resolver rotation logic may reuse it.

## Test plan
- icw2_base=5'h08, resolved_index=3, int_request pulsed, two INTA pulses:
  - isr_set once with ack_index=3;
  - data_out=8'h43 with data_oe during the second pulse;
  - freeze spans both pulses.
- int_request high then low before first INTA fall → no isr_set, vector 8'h47.
- isr_reg=8'b0010_0100, zero_level=4, OCW2=8'h20 → isr_clr with clr_index=5.
- OCW2=8'h62 → isr_clr with clr_index=2. OCW2=8'h20 with isr_reg=0 → no strobe.
- PIC_AEOI_EN, aeoi=1, resolved_index=6 → isr_clr with clr_index=6, 2 cycles after the second INTA rise. Simultaneous OCW2 EOI is deferred by one cycle.
- reset_n low during GAP → data_oe, freeze and int_out are 0 at once; after release the block sits in IDLE.
